// File: rtl/gate_sensor_conditioner_if.sv
// Bundle between the V_GPIO photo-beam inputs and the car-detection FSM.
// glitch_count is present only when GATE_SENSOR_GLITCH_CNT_EN is defined.
interface gate_sensor_conditioner_if;
  logic       outer_raw;
  logic       inner_raw;
  logic       outer;
  logic       inner;
  logic       outer_rise;
  logic       outer_fall;
  logic       inner_rise;
  logic       inner_fall;
  logic [1:0] fault;
`ifdef GATE_SENSOR_GLITCH_CNT_EN
  logic [7:0] glitch_count;
`endif

  // Source of raw samples, consumer of conditioned levels/pulses.
  modport master (
    output outer_raw, inner_raw,
    input  outer, inner, outer_rise, outer_fall, inner_rise, inner_fall, fault
`ifdef GATE_SENSOR_GLITCH_CNT_EN
    , input glitch_count
`endif
  );

  // The conditioner itself.
  modport slave (
    input  outer_raw, inner_raw,
    output outer, inner, outer_rise, outer_fall, inner_rise, inner_fall, fault
`ifdef GATE_SENSOR_GLITCH_CNT_EN
    , output glitch_count
`endif
  );
endinterface

// File: rtl/gate_sensor_conditioner.sv
// Photo-beam conditioner: per channel a 2-flop synchronizer, consecutive-sample
// debouncer, registered rise/fall pulses and a stuck-high fault flag.
// Lane 1 = outer, lane 0 = inner (matches fault bit order).
// Optional rejected-glitch counter: define GATE_SENSOR_GLITCH_CNT_EN.

module gsc_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STUCK_CYCLES    = 500000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall,
  output logic stuck,
  output logic rej
);
  localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic [1:0]    sync_pipe;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] st_cnt;
  logic          sync, flip, lvl_nxt;

  assign sync    = sync_pipe[1];
  assign flip    = (sync != lvl) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign lvl_nxt = flip ? sync : lvl;
  // A pending change abandoned because sync fell back to the clean level.
  assign rej     = (db_cnt != '0) && (sync == lvl);

  // Two-flop synchronizer for the asynchronous beam input.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[0], raw};
  end

  // Debounce: count consecutive disagreeing samples, flip and pulse on completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lvl    <= 1'b0;
      db_cnt <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= flip &&  sync;
      fall <= flip && !sync;
      if (sync == lvl) begin
        db_cnt <= '0;
      end else if (flip) begin
        lvl    <= sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Stuck detection: saturating high-time counter; clears alongside the fall pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_cnt <= '0;
      stuck  <= 1'b0;
    end else if (!lvl_nxt) begin
      st_cnt <= '0;
      stuck  <= 1'b0;
    end else if (lvl && st_cnt != SW'(STUCK_CYCLES)) begin
      st_cnt <= st_cnt + 1'b1;
      if (st_cnt == SW'(STUCK_CYCLES - 1)) stuck <= 1'b1;
    end
  end
endmodule

module gate_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STUCK_CYCLES    = 500000000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  gate_sensor_conditioner_if.slave   sif
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] raw, lvl, rise, fall, stuck, rej;

  assign raw = {sif.outer_raw, sif.inner_raw};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gsc_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw[i]),
      .lvl     (lvl[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .stuck   (stuck[i]),
      .rej     (rej[i])
    );
  end

  assign sif.outer      = lvl[1];
  assign sif.inner      = lvl[0];
  assign sif.outer_rise = rise[1];
  assign sif.outer_fall = fall[1];
  assign sif.inner_rise = rise[0];
  assign sif.inner_fall = fall[0];
  assign sif.fault      = stuck;

`ifdef GATE_SENSOR_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
  logic [8:0] gc_sum;

  assign gc_sum           = {1'b0, glitch_cnt} + 9'(rej[0]) + 9'(rej[1]);
  assign sif.glitch_count = glitch_cnt;

  // Saturating count of rejected transitions across both channels.
  always_ff @(posedge clk) begin
    if (!reset_n) glitch_cnt <= '0;
    else          glitch_cnt <= (gc_sum > 9'd255) ? 8'd255 : gc_sum[7:0];
  end
`endif
endmodule

// File: tb/tb_gate_sensor_conditioner.sv
// Scoreboard bench for gate_sensor_conditioner (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20).
// Stimulus pushes hand-computed output events; the monitor pops one whenever a
// pulse fires or fault changes. Covers GATE_SENSOR_GLITCH_CNT_EN when defined.
module tb_gate_sensor_conditioner;
  localparam int D = 4;
  localparam int S = 20;

  // Raw driven at the negedge after edge t is first sampled at edge t+1 and the
  // clean level flips at edge t+1+D+1.
  localparam int LAT = D + 2;

  typedef struct {
    int         e;     // edge index after which the event is visible
    logic [3:0] p;     // {outer_rise, outer_fall, inner_rise, inner_fall}
    logic [1:0] l;     // {outer, inner}
    logic [1:0] f;     // fault
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   ecount = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  q[$];
  logic [1:0] fault_prev = 2'b00;

  gate_sensor_conditioner_if sif ();

  gate_sensor_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .STUCK_CYCLES    (S)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic ev_t mk(input int e, input logic [3:0] p, input logic [1:0] l,
                             input logic [1:0] f);
    ev_t v;
    v.e = e; v.p = p; v.l = l; v.f = f;
    return v;
  endfunction

  // Monitor: any pulse or fault change must match the next expected event.
  always @(negedge clk) begin
    logic [3:0] p;
    ev_t x;
    p = {sif.outer_rise, sif.outer_fall, sif.inner_rise, sif.inner_fall};
    if (p != 4'b0000 || sif.fault != fault_prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: edge %0d pulses %b lvl %b fault %b", ecount, p,
                 {sif.outer, sif.inner}, sif.fault);
      end else begin
        x = q.pop_front();
        if (x.e != ecount || x.p != p || x.l != {sif.outer, sif.inner} || x.f != sif.fault) begin
          fails++;
          $display("FAIL event: got edge %0d p %b l %b f %b, expected edge %0d p %b l %b f %b",
                   ecount, p, {sif.outer, sif.inner}, sif.fault, x.e, x.p, x.l, x.f);
        end
      end
    end
    fault_prev = sif.fault;
  end

  initial begin
    int t;
    sif.outer_raw = 1'b0;
    sif.inner_raw = 1'b0;

    // Reset state
    cyc(10);
    chk("reset_outputs", int'({sif.outer, sif.inner, sif.outer_rise, sif.outer_fall,
                               sif.inner_rise, sif.inner_fall, sif.fault}), 0);
`ifdef GATE_SENSOR_GLITCH_CNT_EN
    chk("reset_glitch_count", int'(sif.glitch_count), 0);
`endif
    reset_n = 1'b1;
    cyc(4);

    // Outer rise, then held long enough to trip the stuck fault, then dropped
    t = ecount;
    sif.outer_raw = 1'b1;
    q.push_back(mk(t + LAT,          4'b1000, 2'b10, 2'b00));
    q.push_back(mk(t + LAT + S,      4'b0000, 2'b10, 2'b10));
    cyc(LAT - 1);
    chk("outer_before_flip", int'(sif.outer), 0);
    cyc(1);
    chk("outer_after_flip", int'(sif.outer), 1);
    chk("inner_quiet", int'({sif.inner, sif.inner_rise, sif.inner_fall}), 0);
    cyc(S - 1);
    chk("fault_not_yet", int'(sif.fault), 0);
    cyc(30 - (S - 1));
    t = ecount;
    sif.outer_raw = 1'b0;
    q.push_back(mk(t + LAT,          4'b0100, 2'b00, 2'b00));
    cyc(LAT + 4);

    // Inner glitch: 3 sampled-high cycles is one short of a flip
    sif.inner_raw = 1'b1;
    cyc(3);
    sif.inner_raw = 1'b0;
    cyc(10);
    chk("glitch_inner_level", int'(sif.inner), 0);
`ifdef GATE_SENSOR_GLITCH_CNT_EN
    chk("glitch_count_one", int'(sif.glitch_count), 1);
`endif

    // Both channels rise together, then fall together
    t = ecount;
    sif.outer_raw = 1'b1;
    sif.inner_raw = 1'b1;
    q.push_back(mk(t + LAT,          4'b1010, 2'b11, 2'b00));
    cyc(LAT + 2);
    t = ecount;
    sif.outer_raw = 1'b0;
    sif.inner_raw = 1'b0;
    q.push_back(mk(t + LAT,          4'b0101, 2'b00, 2'b00));
    cyc(LAT + 4);
`ifdef GATE_SENSOR_GLITCH_CNT_EN
    chk("glitch_count_unchanged", int'(sif.glitch_count), 1);
`endif

    // Reset mid-debounce of inner, released with raw still high
    sif.inner_raw = 1'b1;
    cyc(2);
    reset_n = 1'b0;
    cyc(2);
    t = ecount;
    reset_n = 1'b1;
    q.push_back(mk(t + LAT,          4'b0010, 2'b01, 2'b00));
    cyc(1);
    chk("inner_after_release", int'(sif.inner), 0);
`ifdef GATE_SENSOR_GLITCH_CNT_EN
    chk("glitch_count_reset", int'(sif.glitch_count), 0);
`endif
    cyc(LAT + 2);
    chk("inner_high_after_reset", int'(sif.inner), 1);
    t = ecount;
    sif.inner_raw = 1'b0;
    q.push_back(mk(t + LAT,          4'b0001, 2'b00, 2'b00));
    cyc(LAT + 4);

    chk("final_levels", int'({sif.outer, sif.inner, sif.fault}), 0);
    chk("events_pending", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
